// File: rtl/snake_body_if.sv
// Bundle between the game FSM / matrix driver (master) and the snake body engine (slave).
interface snake_body_if #(
    parameter int COORD_BITS = 2,
    parameter int MAX_LEN    = 16
);
    localparam int POS_W  = 2 * COORD_BITS;
    localparam int SIZE_W = $clog2(MAX_LEN + 1);

    logic              step;
    logic [1:0]        dir;
    logic              apple_valid;
    logic [POS_W-1:0]  apple_pos;
    logic              render_start;
    logic              busy;
    logic [POS_W-1:0]  head_pos;
    logic [SIZE_W-1:0] size;
    logic              ate;
    logic              game_over;
    logic              win;
    logic              render_valid;
    logic [POS_W-1:0]  render_pos;
    logic              render_last;

    modport master (
        output step, dir, apple_valid, apple_pos, render_start,
        input  busy, head_pos, size, ate, game_over, win,
               render_valid, render_pos, render_last
    );

    modport slave (
        input  step, dir, apple_valid, apple_pos, render_start,
        output busy, head_pos, size, ate, game_over, win,
               render_valid, render_pos, render_last
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body store, mover, collision checker and render streamer (head at body[0]).
// Optional macro SNAKE_WRAP_EN: coordinates wrap at the grid edge instead of hitting a wall.
module snake_body_engine #(
    parameter int                        COORD_BITS = 2,
    parameter int                        MAX_LEN    = 16,
    parameter logic [2*COORD_BITS-1:0]   START_POS  = 4'b0101
) (
    input  logic        clock,
    input  logic        reset,
    snake_body_if.slave bus
);
    localparam int POS_W  = 2 * COORD_BITS;
    localparam int SIZE_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam logic [SIZE_W-1:0]     ONE_S = SIZE_W'(1);
    localparam logic [SIZE_W-1:0]     MAX_S = SIZE_W'(MAX_LEN);
    localparam logic [COORD_BITS:0]   ONE_C = (COORD_BITS + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_UPDATE, S_RENDER} state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  body_q [MAX_LEN];
    logic [POS_W-1:0]  body_d [MAX_LEN];
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] idx_q, idx_d;
    logic [1:0]        last_dir_q, last_dir_d;
    logic [1:0]        eff_dir_q, eff_dir_d;
    logic [POS_W-1:0]  next_head_q, next_head_d;
    logic              eat_q, eat_d;
    logic              wall_q, wall_d;
    logic              hit_q, hit_d;
    logic              ate_q, ate_d;
    logic              game_over_q, game_over_d;
    logic              win_q, win_d;

    logic [1:0]        eff_dir_c;
    logic [POS_W:0]    step_res_c;
    logic [POS_W-1:0]  cur_seg;
    logic              idx_last;

    // Returns {out_of_grid, new_pos}; the extra coordinate bit catches under/overflow before truncation.
    function automatic logic [POS_W:0] step_cell(input logic [POS_W-1:0] pos, input logic [1:0] d);
        logic [COORD_BITS:0] x;
        logic [COORD_BITS:0] y;
        logic                oob;
        x = {1'b0, pos[COORD_BITS-1:0]};
        y = {1'b0, pos[POS_W-1:COORD_BITS]};
        case (d)
            2'b00:   x = x + ONE_C;
            2'b01:   x = x - ONE_C;
            2'b10:   y = y - ONE_C;
            default: y = y + ONE_C;
        endcase
`ifdef SNAKE_WRAP_EN
        oob = 1'b0;
`else
        oob = x[COORD_BITS] | y[COORD_BITS];
`endif
        return {oob, y[COORD_BITS-1:0], x[COORD_BITS-1:0]};
    endfunction

    assign cur_seg  = body_q[idx_q[IDX_W-1:0]];
    assign idx_last = (idx_q == size_q - ONE_S);

    always_comb begin
        state_d     = state_q;
        body_d      = body_q;
        size_d      = size_q;
        idx_d       = idx_q;
        last_dir_d  = last_dir_q;
        eff_dir_d   = eff_dir_q;
        next_head_d = next_head_q;
        eat_d       = eat_q;
        wall_d      = wall_q;
        hit_d       = hit_q;
        ate_d       = 1'b0;
        game_over_d = game_over_q;
        win_d       = win_q;
        eff_dir_c   = bus.dir;
        step_res_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.step && !game_over_q && !win_q) begin
                    // A direct reversal would fold the head onto body[1]; keep going the old way.
                    if (size_q > ONE_S && bus.dir[1] == last_dir_q[1] && bus.dir[0] != last_dir_q[0]) begin
                        eff_dir_c = last_dir_q;
                    end
                    step_res_c  = step_cell(body_q[0], eff_dir_c);
                    eff_dir_d   = eff_dir_c;
                    next_head_d = step_res_c[POS_W-1:0];
                    wall_d      = step_res_c[POS_W];
                    eat_d       = bus.apple_valid && (step_res_c[POS_W-1:0] == bus.apple_pos);
                    hit_d       = 1'b0;
                    idx_d       = '0;
                    state_d     = step_res_c[POS_W] ? S_UPDATE : S_CHECK;
                end else if (bus.render_start && !bus.step) begin
                    idx_d   = '0;
                    state_d = S_RENDER;
                end
            end
            S_CHECK: begin
                // The tail cell is free to enter unless the snake grows this move.
                if (cur_seg == next_head_q && !(idx_last && !eat_q)) begin
                    hit_d = 1'b1;
                end
                idx_d = idx_q + ONE_S;
                if (idx_last) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (hit_q || wall_q) begin
                    game_over_d = 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        body_d[i] = body_q[i-1];
                    end
                    body_d[0]  = next_head_q;
                    last_dir_d = eff_dir_q;
                    if (eat_q) begin
                        ate_d = 1'b1;
                        if (size_q < MAX_S) begin
                            size_d = size_q + ONE_S;
                        end
                        win_d = (size_d == MAX_S);
                    end
                end
                state_d = S_IDLE;
            end
            default: begin
                idx_d = idx_q + ONE_S;
                if (idx_last) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_q[i] <= (i == 0) ? START_POS : '0;
            end
            size_q      <= ONE_S;
            idx_q       <= '0;
            last_dir_q  <= 2'b00;
            eff_dir_q   <= 2'b00;
            next_head_q <= '0;
            eat_q       <= 1'b0;
            wall_q      <= 1'b0;
            hit_q       <= 1'b0;
            ate_q       <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            body_q      <= body_d;
            size_q      <= size_d;
            idx_q       <= idx_d;
            last_dir_q  <= last_dir_d;
            eff_dir_q   <= eff_dir_d;
            next_head_q <= next_head_d;
            eat_q       <= eat_d;
            wall_q      <= wall_d;
            hit_q       <= hit_d;
            ate_q       <= ate_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.head_pos     = body_q[0];
    assign bus.size         = size_q;
    assign bus.ate          = ate_q;
    assign bus.game_over    = game_over_q;
    assign bus.win          = win_q;
    assign bus.render_valid = (state_q == S_RENDER);
    assign bus.render_pos   = (state_q == S_RENDER) ? cur_seg : '0;
    assign bus.render_last  = (state_q == S_RENDER) && idx_last;
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: wall, growth, reversal, self hit, tail rule, render, win.
module tb_snake_body_engine;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   bn;
    int   rn;
    logic [3:0] rpos [20];
    logic       rlast [20];
    logic [1:0] wdir [15];
    logic [3:0] wpos [15];

    snake_body_if #(.COORD_BITS(2), .MAX_LEN(16)) bus ();

    snake_body_engine #(.COORD_BITS(2), .MAX_LEN(16), .START_POS(4'b0101)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Issues one step and returns the number of busy cycles observed afterwards.
    task automatic do_step(input logic [1:0] d, input logic av, input logic [3:0] ap, output int busy_n);
        @(negedge clk);
        bus.step = 1'b1; bus.dir = d; bus.apple_valid = av; bus.apple_pos = ap;
        @(negedge clk);
        bus.step = 1'b0; bus.apple_valid = 1'b0;
        busy_n = 0;
        while (bus.busy && busy_n < 100) begin
            busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic grow(input string tag, input logic [1:0] d, input logic [3:0] p, input int new_size);
        int n;
        do_step(d, 1'b1, p, n);
        check({tag, "_busy"}, n, new_size);
        check({tag, "_head"}, bus.head_pos, p);
    endtask

    task automatic run_render();
        @(negedge clk); bus.render_start = 1'b1;
        @(negedge clk); bus.render_start = 1'b0;
        rn = 0;
        while (bus.render_valid && rn < 20) begin
            rpos[rn]  = bus.render_pos;
            rlast[rn] = bus.render_last;
            rn++;
            @(negedge clk);
        end
    endtask

    task automatic ignored_step(input string tag);
        @(negedge clk); bus.step = 1'b1; bus.dir = 2'b00;
        @(negedge clk); bus.step = 1'b0;
        check(tag, bus.busy, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        bus.step = 1'b0; bus.dir = 2'b00; bus.apple_valid = 1'b0; bus.apple_pos = 4'h0;
        bus.render_start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        check("rst_head", bus.head_pos, 4'b0101);
        check("rst_size", bus.size, 1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ate", bus.ate, 1'b0);
        check("rst_go", bus.game_over, 1'b0);
        check("rst_win", bus.win, 1'b0);
        check("rst_rvalid", bus.render_valid, 1'b0);
        check("rst_rpos", bus.render_pos, 4'b0000);
        check("rst_rlast", bus.render_last, 1'b0);

        // Wall collision
        do_step(2'b00, 1'b0, 4'h0, bn);
        check("wall1_busy", bn, 2);
        check("wall1_head", bus.head_pos, 4'b0110);
        check("wall1_size", bus.size, 1);
        check("wall1_ate", bus.ate, 1'b0);
        do_step(2'b00, 1'b0, 4'h0, bn);
        check("wall2_head", bus.head_pos, 4'b0111);
        check("wall2_go", bus.game_over, 1'b0);
        do_step(2'b00, 1'b0, 4'h0, bn);
        check("wall3_busy", bn, 1);
        check("wall3_go", bus.game_over, 1'b1);
        check("wall3_head", bus.head_pos, 4'b0111);
        ignored_step("wall_ignored_busy");
        check("wall_ignored_head", bus.head_pos, 4'b0111);

        // Eating and growth
        do_reset();
        check("eat_rst_go", bus.game_over, 1'b0);
        do_step(2'b00, 1'b0, 4'h0, bn);
        do_step(2'b00, 1'b1, 4'b0111, bn);
        check("eat_busy", bn, 2);
        check("eat_ate", bus.ate, 1'b1);
        check("eat_size", bus.size, 2);
        check("eat_head", bus.head_pos, 4'b0111);
        @(negedge clk);
        check("eat_ate_pulse", bus.ate, 1'b0);

        // Render of a two-segment body
        run_render();
        check("rnd_count", rn, 2);
        check("rnd_pos0", rpos[0], 4'b0111);
        check("rnd_pos1", rpos[1], 4'b0110);
        check("rnd_last0", rlast[0], 1'b0);
        check("rnd_last1", rlast[1], 1'b1);

        // Reset during the first render cycle
        @(negedge clk); bus.render_start = 1'b1;
        @(negedge clk); bus.render_start = 1'b0;
        check("rr_valid0", bus.render_valid, 1'b1);
        check("rr_pos0", bus.render_pos, 4'b0111);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rr_valid", bus.render_valid, 1'b0);
        check("rr_size", bus.size, 1);
        check("rr_head", bus.head_pos, 4'b0101);
        check("rr_busy", bus.busy, 1'b0);

        // Reverse rejection
        grow("rev_grow", 2'b00, 4'b0110, 2);
        do_step(2'b01, 1'b0, 4'h0, bn);
        check("rev_busy", bn, 3);
        check("rev_head", bus.head_pos, 4'b0111);
        check("rev_size", bus.size, 2);
        check("rev_go", bus.game_over, 1'b0);

        // Self collision
        do_reset();
        grow("sc_g1", 2'b01, 4'b0100, 2);
        grow("sc_g2", 2'b10, 4'b0000, 3);
        grow("sc_g3", 2'b00, 4'b0001, 4);
        grow("sc_g4", 2'b00, 4'b0010, 5);
        do_step(2'b11, 1'b0, 4'h0, bn);
        check("sc_down_head", bus.head_pos, 4'b0110);
        do_step(2'b01, 1'b0, 4'h0, bn);
        check("sc_left_head", bus.head_pos, 4'b0101);
        check("sc_left_go", bus.game_over, 1'b0);
        do_step(2'b10, 1'b0, 4'h0, bn);
        check("sc_up_busy", bn, 6);
        check("sc_go", bus.game_over, 1'b1);
        check("sc_size", bus.size, 5);
        check("sc_head", bus.head_pos, 4'b0101);
        ignored_step("sc_ignored_busy");
        run_render();
        check("sc_rnd_count", rn, 5);
        check("sc_rnd_p1", rpos[1], 4'b0110);
        check("sc_rnd_p2", rpos[2], 4'b0010);
        check("sc_rnd_p3", rpos[3], 4'b0001);
        check("sc_rnd_p4", rpos[4], 4'b0000);
        check("sc_rnd_last4", rlast[4], 1'b1);

        // Tail exemption without apple
        do_reset();
        grow("te_g1", 2'b00, 4'b0110, 2);
        grow("te_g2", 2'b11, 4'b1010, 3);
        grow("te_g3", 2'b01, 4'b1001, 4);
        do_step(2'b10, 1'b0, 4'h0, bn);
        check("te_busy", bn, 5);
        check("te_go", bus.game_over, 1'b0);
        check("te_head", bus.head_pos, 4'b0101);
        check("te_size", bus.size, 4);

        // Same move with the apple on the tail cell
        do_reset();
        grow("ta_g1", 2'b00, 4'b0110, 2);
        grow("ta_g2", 2'b11, 4'b1010, 3);
        grow("ta_g3", 2'b01, 4'b1001, 4);
        do_step(2'b10, 1'b1, 4'b0101, bn);
        check("ta_go", bus.game_over, 1'b1);
        check("ta_size", bus.size, 4);
        check("ta_head", bus.head_pos, 4'b1001);
        check("ta_ate", bus.ate, 1'b0);

        // Fill the whole grid to reach the win condition
        wdir[0]  = 2'b01; wpos[0]  = 4'b0100;
        wdir[1]  = 2'b10; wpos[1]  = 4'b0000;
        wdir[2]  = 2'b00; wpos[2]  = 4'b0001;
        wdir[3]  = 2'b00; wpos[3]  = 4'b0010;
        wdir[4]  = 2'b00; wpos[4]  = 4'b0011;
        wdir[5]  = 2'b11; wpos[5]  = 4'b0111;
        wdir[6]  = 2'b01; wpos[6]  = 4'b0110;
        wdir[7]  = 2'b11; wpos[7]  = 4'b1010;
        wdir[8]  = 2'b00; wpos[8]  = 4'b1011;
        wdir[9]  = 2'b11; wpos[9]  = 4'b1111;
        wdir[10] = 2'b01; wpos[10] = 4'b1110;
        wdir[11] = 2'b01; wpos[11] = 4'b1101;
        wdir[12] = 2'b01; wpos[12] = 4'b1100;
        wdir[13] = 2'b10; wpos[13] = 4'b1000;
        wdir[14] = 2'b00; wpos[14] = 4'b1001;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            grow($sformatf("win_g%0d", i), wdir[i], wpos[i], i + 2);
            if (i == 13) check("win_not_yet", bus.win, 1'b0);
        end
        check("win_size", bus.size, 16);
        check("win_flag", bus.win, 1'b1);
        check("win_go", bus.game_over, 1'b0);
        ignored_step("win_ignored_busy");
        check("win_ignored_size", bus.size, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
